// File: rtl/fetch_stage_pkg.sv
// Shared core definitions for the RV32I fetch front end.
// IF/ID bundle layout and fetch-related constants.
package fetch_stage_pkg;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] NOP_ENC = 32'h0000_0013;
    localparam logic [XLEN-1:0] PC_INC  = 32'd4;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
        logic            valid;
    } if_id_t;

    function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_stage_pc_redirect_buffer.sv
// Holds a redirect that arrives while the front end is stalled, aligns targets
// and keeps sticky flags for misaligned targets and overwritten redirects.
module pc_redirect_buffer
    import fetch_stage_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_target,
    output logic [XLEN-1:0] aligned_target,
    output logic            pending_valid,
    output logic [XLEN-1:0] pending_target,
    output logic            misaligned_err,
    output logic            redirect_overrun
);

    assign aligned_target = align_word(redirect_target);

    always_ff @(posedge clk) begin
        if (rst) begin
            pending_valid    <= 1'b0;
            pending_target   <= '0;
            misaligned_err   <= 1'b0;
            redirect_overrun <= 1'b0;
        end else begin
            if (redirect_valid && (redirect_target[1:0] != 2'b00))
                misaligned_err <= 1'b1;
            if (!stall) begin
                // pending target is consumed (or superseded) on any advance
                pending_valid <= 1'b0;
                if (redirect_valid && pending_valid)
                    redirect_overrun <= 1'b1;
            end else if (redirect_valid) begin
                pending_valid  <= 1'b1;
                pending_target <= aligned_target;
                if (pending_valid)
                    redirect_overrun <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC, addresses the ROM and fills IF/ID.
// Redirects use single-delay-slot semantics; the word at the old PC is kept.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC  = 32'h0000_0000,
    parameter logic [XLEN-1:0] NOP_INSTR = NOP_ENC
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic            flush,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_target,
    output logic [XLEN-1:0] instr_addr,
    input  logic [XLEN-1:0] instr_in,
    output logic [XLEN-1:0] if_id_pc,
    output logic [XLEN-1:0] if_id_instr,
    output logic            if_id_valid,
    output logic [XLEN-1:0] fetch_count,
    output logic            misaligned_err,
    output logic            redirect_overrun
);

    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] next_pc;
    logic [XLEN-1:0] aligned_target;
    logic [XLEN-1:0] pending_target;
    logic            pending_valid;
    if_id_t          if_id;

    pc_redirect_buffer u_redirect_buf (
        .clk              (clk),
        .rst              (rst),
        .stall            (stall),
        .redirect_valid   (redirect_valid),
        .redirect_target  (redirect_target),
        .aligned_target   (aligned_target),
        .pending_valid    (pending_valid),
        .pending_target   (pending_target),
        .misaligned_err   (misaligned_err),
        .redirect_overrun (redirect_overrun)
    );

    always_comb begin
        next_pc = pc + PC_INC;
        if (redirect_valid)
            next_pc = aligned_target;
        else if (pending_valid)
            next_pc = pending_target;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc          <= RESET_PC;
            if_id       <= '{pc: '0, instr: NOP_INSTR, valid: 1'b0};
            fetch_count <= '0;
        end else if (!stall) begin
            pc <= next_pc;
            if (flush) begin
                if_id <= '{pc: pc, instr: NOP_INSTR, valid: 1'b0};
            end else begin
                if_id       <= '{pc: pc, instr: instr_in, valid: 1'b1};
                fetch_count <= fetch_count + 1'b1;
            end
        end else if (flush) begin
            // flush still squashes the held word while stalled
            if_id.instr <= NOP_INSTR;
            if_id.valid <= 1'b0;
        end
    end

    assign instr_addr  = pc;
    assign if_id_pc    = if_id.pc;
    assign if_id_instr = if_id.instr;
    assign if_id_valid = if_id.valid;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed table, corner sequences and
// randomized traffic checked against a cycle-level reference model.
module tb_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst, stall, flush, redirect_valid;
    logic [31:0] redirect_target, instr_addr, instr_in;
    logic [31:0] if_id_pc, if_id_instr, fetch_count;
    logic        if_id_valid, misaligned_err, redirect_overrun;

    int n_checks = 0;
    int n_fail   = 0;

    fetch_stage dut (
        .clk              (clk),
        .rst              (rst),
        .stall            (stall),
        .flush            (flush),
        .redirect_valid   (redirect_valid),
        .redirect_target  (redirect_target),
        .instr_addr       (instr_addr),
        .instr_in         (instr_in),
        .if_id_pc         (if_id_pc),
        .if_id_instr      (if_id_instr),
        .if_id_valid      (if_id_valid),
        .fetch_count      (fetch_count),
        .misaligned_err   (misaligned_err),
        .redirect_overrun (redirect_overrun)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] rom(input logic [31:0] a);
        if (a[1:0] != 2'b00 || a >= 32'h0000_1000) return NOP;
        if (a == 32'h0) return 32'hff60_0293;
        return (a * 32'h0100_0193) ^ 32'h00a0_0113;
    endfunction

    assign instr_in = rom(instr_addr);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model state, updated from the rules of the stage.
    logic [31:0] m_pc, m_ipc, m_instr, m_cnt, m_pt;
    logic        m_valid, m_mis, m_ovr, m_pv;

    task automatic model_step(input logic r, input logic s, input logic f,
                              input logic rv, input logic [31:0] t);
        logic [31:0] at;
        at = t & 32'hffff_fffc;
        if (r) begin
            m_pc = 0; m_ipc = 0; m_instr = NOP; m_valid = 0; m_cnt = 0;
            m_mis = 0; m_ovr = 0; m_pv = 0; m_pt = 0;
            return;
        end
        if (rv && t[1:0] != 2'b00) m_mis = 1;
        if (!s) begin
            m_ipc   = m_pc;
            m_instr = f ? NOP : rom(m_pc);
            m_valid = !f;
            if (!f) m_cnt = m_cnt + 1;
            if (rv && m_pv) m_ovr = 1;
            m_pc = rv ? at : (m_pv ? m_pt : m_pc + 4);
            m_pv = 0;
        end else begin
            if (f) begin m_instr = NOP; m_valid = 0; end
            if (rv) begin
                if (m_pv) m_ovr = 1;
                m_pv = 1;
                m_pt = at;
            end
        end
    endtask

    task automatic cyc(input logic r, input logic s, input logic f,
                       input logic rv, input logic [31:0] t);
        @(negedge clk);
        rst = r; stall = s; flush = f; redirect_valid = rv; redirect_target = t;
        @(posedge clk);
        #1;
        model_step(r, s, f, rv, t);
    endtask

    task automatic check_model(input string tag);
        check({tag, ".addr"},  instr_addr,  m_pc);
        check({tag, ".pc"},    if_id_pc,    m_ipc);
        check({tag, ".instr"}, if_id_instr, m_instr);
        check({tag, ".valid"}, {31'b0, if_id_valid}, {31'b0, m_valid});
        check({tag, ".cnt"},   fetch_count, m_cnt);
        check({tag, ".mis"},   {31'b0, misaligned_err}, {31'b0, m_mis});
        check({tag, ".ovr"},   {31'b0, redirect_overrun}, {31'b0, m_ovr});
    endtask

    typedef struct {
        logic        s, f, rv;
        logic [31:0] t;
        logic [31:0] e_addr, e_pc, e_cnt;
        logic        e_valid, e_mis, e_ovr;
    } vec_t;

    vec_t vt[17];

    initial begin
        rst = 1; stall = 0; flush = 0; redirect_valid = 0; redirect_target = 0;
        //            s  f  rv  target   addr     if_id_pc cnt  v  mis ovr
        vt[0]  = '{0, 0, 0, 32'h0,  32'h04, 32'h00, 1,  1, 0, 0};
        vt[1]  = '{0, 0, 0, 32'h0,  32'h08, 32'h04, 2,  1, 0, 0};
        vt[2]  = '{0, 0, 0, 32'h0,  32'h0C, 32'h08, 3,  1, 0, 0};
        vt[3]  = '{0, 0, 0, 32'h0,  32'h10, 32'h0C, 4,  1, 0, 0};
        vt[4]  = '{1, 0, 0, 32'h0,  32'h10, 32'h0C, 4,  1, 0, 0};
        vt[5]  = '{1, 0, 1, 32'h5C, 32'h10, 32'h0C, 4,  1, 0, 0};
        vt[6]  = '{1, 0, 0, 32'h0,  32'h10, 32'h0C, 4,  1, 0, 0};
        vt[7]  = '{0, 0, 0, 32'h0,  32'h5C, 32'h10, 5,  1, 0, 0};
        vt[8]  = '{0, 0, 0, 32'h0,  32'h60, 32'h5C, 6,  1, 0, 0};
        vt[9]  = '{0, 1, 0, 32'h0,  32'h64, 32'h60, 6,  0, 0, 0};
        vt[10] = '{1, 0, 1, 32'h40, 32'h64, 32'h60, 6,  0, 0, 0};
        vt[11] = '{1, 0, 1, 32'h80, 32'h64, 32'h60, 6,  0, 0, 1};
        vt[12] = '{0, 0, 0, 32'h0,  32'h80, 32'h64, 7,  1, 0, 1};
        vt[13] = '{0, 0, 1, 32'h4E, 32'h4C, 32'h80, 8,  1, 1, 1};
        vt[14] = '{0, 0, 0, 32'h0,  32'h50, 32'h4C, 9,  1, 1, 1};
        vt[15] = '{1, 1, 0, 32'h0,  32'h50, 32'h4C, 9,  0, 1, 1};
        vt[16] = '{0, 0, 0, 32'h0,  32'h54, 32'h50, 10, 1, 1, 1};

        cyc(1, 0, 0, 0, 0);
        check("rst.addr",  instr_addr, 32'h0);
        check("rst.pc",    if_id_pc, 32'h0);
        check("rst.instr", if_id_instr, NOP);
        check("rst.valid", {31'b0, if_id_valid}, 32'h0);
        check("rst.cnt",   fetch_count, 32'h0);
        check("rst.flags", {30'b0, misaligned_err, redirect_overrun}, 32'h0);

        for (int i = 0; i < 17; i++) begin
            cyc(0, vt[i].s, vt[i].f, vt[i].rv, vt[i].t);
            check($sformatf("vec%0d.addr", i), instr_addr, vt[i].e_addr);
            check($sformatf("vec%0d.pc", i), if_id_pc, vt[i].e_pc);
            check($sformatf("vec%0d.instr", i), if_id_instr,
                  vt[i].e_valid ? rom(vt[i].e_pc) : NOP);
            check($sformatf("vec%0d.valid", i), {31'b0, if_id_valid}, {31'b0, vt[i].e_valid});
            check($sformatf("vec%0d.cnt", i), fetch_count, vt[i].e_cnt);
            check($sformatf("vec%0d.mis", i), {31'b0, misaligned_err}, {31'b0, vt[i].e_mis});
            check($sformatf("vec%0d.ovr", i), {31'b0, redirect_overrun}, {31'b0, vt[i].e_ovr});
        end

        // Reset with a redirect pending: pending target must be discarded.
        cyc(0, 1, 0, 1, 32'h200);
        cyc(1, 1, 0, 0, 0);
        check("rstpend.flags", {30'b0, misaligned_err, redirect_overrun}, 32'h0);
        cyc(0, 0, 0, 0, 0);
        check("rstpend.addr", instr_addr, 32'h4);
        check("rstpend.pc", if_id_pc, 32'h0);
        check("rstpend.instr", if_id_instr, 32'hff60_0293);

        // Delay slot: branch at 0x34 sits in IF/ID while 0x38 is fetched.
        while (instr_addr != 32'h38 && instr_addr < 32'h100) cyc(0, 0, 0, 0, 0);
        check("ds.reach", instr_addr, 32'h38);
        check("ds.branch_pc", if_id_pc, 32'h34);
        cyc(0, 0, 0, 1, 32'h48);
        check("ds.slot_pc", if_id_pc, 32'h38);
        check("ds.slot_valid", {31'b0, if_id_valid}, 32'h1);
        check("ds.target_addr", instr_addr, 32'h48);
        cyc(0, 0, 0, 0, 0);
        check("ds.target_pc", if_id_pc, 32'h48);

        // Redirect arriving while one is already pending, on the advance cycle.
        cyc(1, 0, 0, 0, 0);
        cyc(0, 1, 0, 1, 32'h100);
        check("adv_ovr.pre", {31'b0, redirect_overrun}, 32'h0);
        cyc(0, 0, 0, 1, 32'h200);
        check("adv_ovr.flag", {31'b0, redirect_overrun}, 32'h1);
        check("adv_ovr.addr", instr_addr, 32'h200);

        // Randomized traffic against the reference model.
        cyc(1, 0, 0, 0, 0);
        check_model("rnd0");
        for (int i = 0; i < 3000; i++) begin
            logic r, s, f, rv;
            logic [31:0] t;
            r  = ($urandom_range(0, 99) < 2);
            s  = ($urandom_range(0, 99) < 30);
            f  = ($urandom_range(0, 99) < 15);
            rv = ($urandom_range(0, 99) < 20);
            t  = $urandom_range(0, 32'h1100);
            if (($urandom_range(0, 99)) < 3) t = 32'hffff_fffc;
            cyc(r, s, f, rv, t);
            check_model($sformatf("rnd%0d", i + 1));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch front end of the 5-stage pipelined RV32I core.
- Sits directly upstream of the combinational instruction ROM: owns the PC and drives the ROM address.
- Registers the returned word into the IF/ID pipeline register.
- Supports stall, flush, and branch redirect with single-delay-slot semantics. The instruction after a branch always executes; no squash on redirect.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_INSTR, 32'h0000_0013, word driven into IF/ID when empty or flushed (addi x0,x0,0).

Ports:
- clk  input  1  core clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- stall  input  1  hold PC and IF/ID this cycle (decode back-pressure).
- flush  input  1  squash the word being written into IF/ID this cycle.
- redirect_valid  input  1  branch/jump resolved taken this cycle.
- redirect_target  input  32  byte address of the taken target.
- instr_addr  output  32  ROM address; equals the PC register (combinational from the register).
- instr_in  input  32  ROM read data for instr_addr, same cycle.
- if_id_pc  output  32  PC of the latched instruction.
- if_id_instr  output  32  latched instruction.
- if_id_valid  output  1  latched instruction is real (not reset or flush filler).
- fetch_count  output  32  number of instructions committed into IF/ID.
- misaligned_err  output  1  sticky: a redirect target had bits [1:0] != 0.
- redirect_overrun  output  1  sticky: a redirect was overwritten before it was applied.

Behaviour:
- Reset: synchronous and active-high. Clock is clk, reset is rst. rst has priority over all other inputs.
- Reset values:
  - pc = RESET_PC
  - if_id_pc = 0
  - if_id_instr = NOP_INSTR
  - if_id_valid = 0
  - fetch_count = 0
  - misaligned_err = 0
  - redirect_overrun = 0
  - pending_valid = 0
  - pending_target = 0
- Target alignment: every accepted redirect_target has bits [1:0] forced to 00. If the raw target had nonzero bits [1:0], set misaligned_err.
- stall=0 (advance):
  - IF/ID <= {pc, instr_in, 1}.
  - If flush=1, IF/ID instead <= {pc, NOP_INSTR, 0}.
  - fetch_count increments only when the write is not flushed; wraps modulo 2^32.
  - Next PC, in priority order:
    - redirect_valid → aligned redirect_target;
    - else pending_valid → pending_target;
    - else pc+4, wrapping modulo 2^32.
  - pending_valid <= 0.
  - If redirect_valid and pending_valid are both set, the incoming redirect wins and redirect_overrun is set.
- stall=1 (hold):
  - pc holds.
  - IF/ID holds, except flush=1 forces {if_id_pc, NOP_INSTR, 0}. Flush beats stall for IF/ID.
  - If redirect_valid: pending_target <= aligned target and pending_valid <= 1. If pending_valid was already 1, set redirect_overrun (last redirect wins).
  - fetch_count holds.
- Delay slot: the word fetched in the redirect cycle (at the old pc) is latched normally. The target is fetched in the following cycle.
- Latency:
  - instr_addr to if_id_instr: 1 cycle.
  - redirect to first target fetch: 1 cycle, or 1 cycle after stall deasserts if pended.
- Misaligned and out-of-range PCs are passed to the ROM unchanged; the ROM returns NOP for them. This block does not check range.
- Reset mid-stall or with a redirect pending: the pending redirect is discarded and fetch restarts at RESET_PC.

Decomposition:
- Shared core package holds:
  - XLEN = 32;
  - the NOP encoding 32'h0000_0013;
  - PC increment constant 4;
  - IF/ID bundle typedef {pc, instr, valid}.
- One sub-module, pc_redirect_buffer: the pending_valid/pending_target register, overrun flag and target alignment. It is reused later by the JALR/exception path.

Test Plan:
- Reset then 4 unstalled cycles (ROM returns 32'hff600293 at 0) → instr_addr sequence 0,4,8,C; first latch if_id_pc=0, if_id_instr=ff600293, valid=1; fetch_count=4.
- Redirect at pc=0x34 with target 0x48, no stall → IF/ID next gets pc 0x34 (branch), then 0x38 (delay slot); instr_addr=0x48 in the cycle after redirect.
- stall=1 for 3 cycles at pc=0x10 with redirect to 0x5C in stall cycle 2 → pc stays 0x10, IF/ID frozen, fetch_count frozen. On release, IF/ID gets pc 0x10 and next instr_addr=0x5C.
- Two redirects (0x40 then 0x80) during one stall → redirect_overrun=1; fetch resumes at 0x80.
- flush=1 while stall=0 at pc=0x20 → if_id_instr=00000013, valid=0, fetch_count unchanged; pc still advances to 0x24.
- Redirect target 0x4E → instr_addr becomes 0x4C; misaligned_err=1 and stays 1 until rst.
